audio_in_deserializer: RTL

AUDIO_IN_DESERIALIZER -- requirements
Module: audio_in_deserializer

---
 rtl/audio_pkg.sv | 18 +
 rtl/audio_pair_fifo.sv | 74 +++++++
 rtl/audio_in_deserializer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared capture FSM encoding and I2S framing constants
//
// Contents:
//   capture_state_t : IDLE / SKIP / SHIFT / DONE capture states
//   I2S_DELAY_BITS  : BCLK rises ignored after each LRCK edge before the MSB

package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } capture_state_t;

    localparam int I2S_DELAY_BITS = 1;

endpackage

// File: rtl/audio_pair_fifo.sv
// rtl/audio_pair_fifo.sv - stereo pair FIFO with sticky overflow flag
//
// Ports:
//   CLOCK_50, resetn : clock, asynchronous active-low reset
//   clear            : synchronous flush of contents and overflow flag; beats push/pop
//   s_tdata/s_tvalid : push side (no backpressure; a push while full is dropped)
//   m_tdata/m_tvalid : head word / non-empty
//   m_tready         : pop strobe, ignored while empty
//   overflow         : sticky, set when a push is dropped

module audio_pair_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             clear,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop while full frees the slot the same-cycle push lands in.
    assign do_pop  = !clear && m_tready && !empty;
    assign do_push = !clear && s_tvalid && (!full || do_pop);

    assign m_tdata  = mem[rd_ptr[AW-1:0]];
    assign m_tvalid = !empty;

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (s_tvalid && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_in_deserializer.sv
// rtl/audio_in_deserializer.sv - I2S ADC capture into a stereo pair FIFO
//
// Ports:
//   CLOCK_50, resetn           : system clock, asynchronous active-low reset
//   AUD_BCLK, AUD_ADCLRCK      : codec bit clock / word select (low = left), asynchronous
//   AUD_ADCDAT                 : codec serial data, MSB first, one-bit I2S delay
//   clear_audio_in_memory      : flush FIFO, overflow flag, held and partial words
//   read_audio_in              : pop one pair
//   audio_in_available         : FIFO non-empty
//   left/right_channel_audio_in: pair at FIFO head (zero while empty)
//   audio_in_overflow          : sticky, a completed pair was dropped

module audio_in_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  clear_audio_in_memory,
    input  logic                  read_audio_in,
    output logic                  audio_in_available,
    output logic [DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                  audio_in_overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(I2S_DELAY_BITS - 1);

    // [0],[1] synchronize; [2] is the delayed copy for edge detection.
    logic [2:0] bclk_sync;
    logic [2:0] lrck_sync;
    logic [1:0] dat_sync;
    logic       bclk_rise;
    logic       lrck_edge;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[1:0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[0], AUD_ADCDAT};
        end
    end

    assign bclk_rise = bclk_sync[1] && !bclk_sync[2];
    assign lrck_edge = lrck_sync[1] ^ lrck_sync[2];

    capture_state_t        state, state_d;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  channel, channel_d;
    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_word;
    logic                  commit_right;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            channel <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shreg   <= shreg_d;
            channel <= channel_d;
        end
    end

    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        channel_d    = channel;
        commit       = 1'b0;
        // Bits arrive at the LSB end, so a word cut short by LRCK is
        // left-justified by shifting out the bits that never came.
        commit_word  = shreg << (CNT_FULL - bit_cnt);
        commit_right = channel;

        if (clear_audio_in_memory) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (lrck_edge) begin
            if (state == ST_SHIFT) begin
                commit = 1'b1;
            end
            state_d   = ST_SKIP;
            bit_cnt_d = '0;
            shreg_d   = '0;
            channel_d = lrck_sync[1];
        end else if (bclk_rise) begin
            unique case (state)
                ST_SKIP: begin
                    if (bit_cnt == SKIP_LAST) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    shreg_d   = {shreg[DATA_WIDTH-2:0], dat_sync[1]};
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_LAST) begin
                        state_d     = ST_DONE;
                        commit      = 1'b1;
                        commit_word = shreg_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pairing: a right word only forms a pair with a left word captured
    // since the last pair, clear or reset; otherwise it is dropped.
    logic [DATA_WIDTH-1:0]   left_hold;
    logic                    left_valid;
    logic [2*DATA_WIDTH-1:0] pair_tdata;
    logic                    pair_tvalid;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            left_hold   <= '0;
            left_valid  <= 1'b0;
            pair_tdata  <= '0;
            pair_tvalid <= 1'b0;
        end else begin
            pair_tvalid <= 1'b0;
            if (clear_audio_in_memory) begin
                left_hold  <= '0;
                left_valid <= 1'b0;
            end else if (commit) begin
                if (!commit_right) begin
                    left_hold  <= commit_word;
                    left_valid <= 1'b1;
                end else if (left_valid) begin
                    pair_tdata  <= {left_hold, commit_word};
                    pair_tvalid <= 1'b1;
                    left_valid  <= 1'b0;
                end
            end
        end
    end

    logic [2*DATA_WIDTH-1:0] head_tdata;
    logic                    head_tvalid;

    audio_pair_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clear    (clear_audio_in_memory),
        .s_tdata  (pair_tdata),
        .s_tvalid (pair_tvalid),
        .m_tdata  (head_tdata),
        .m_tvalid (head_tvalid),
        .m_tready (read_audio_in),
        .overflow (audio_in_overflow)
    );

    // Gate with non-empty so the outputs read zero straight out of reset.
    assign audio_in_available     = head_tvalid;
    assign left_channel_audio_in  = head_tvalid ? head_tdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign right_channel_audio_in = head_tvalid ? head_tdata[DATA_WIDTH-1:0] : '0;

endmodule
